mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the response watchdog limit in cycles (range 0..65535; 0 disables the watchdog).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 if_req  in  1  instruction-fetch request; held with if_addr stable until if_gnt.
REQ-005 if_addr  in  32  fetch word address.
REQ-006 if_gnt  out  1  fetch request accepted this cycle.
REQ-007 if_rvalid  out  1  fetch response valid, one-cycle pulse.
REQ-008 if_rdata  out  32  fetch response data.
REQ-009 if_err  out  1  fetch response is a timeout error; qualified by if_rvalid.
REQ-010 d_req  in  1  data request; held with d_op, d_addr, d_wdata and d_be stable until d_gnt.
REQ-011 d_op  in  rv32i::mem_op_e  MEM_LOAD or MEM_STORE.
REQ-012 d_addr / d_wdata / d_be  in  32 / 32 / 4  data address, store data, byte enables.
REQ-013 d_gnt / d_rvalid / d_err  out  1 each  same meaning as the if_ signals.
REQ-014 d_rdata  out  32  data response (load data; don't-care for stores).
REQ-015 mem_req / mem_we  out  1 each  shared memory port request; write enable.
REQ-016 mem_addr / mem_wdata / mem_be  out  32 / 32 / 4  shared memory port request fields.
REQ-017 mem_gnt  in  1  memory accepts the request in the cycle mem_req and mem_gnt are both high.
REQ-018 mem_rvalid / mem_rdata  in  1 / 32  memory response; exactly one per accepted request, loads and stores alike.
REQ-019 err_spurious  out  1  sticky flag: a response arrived with no transaction outstanding.

Function
REQ-020 The block SHALL use states IDLE, ISSUE and WAIT_RESP, with a registered owner (IF/D) and a registered last_owner.
REQ-021 At most one transaction SHALL be outstanding at any time.
REQ-022 In IDLE, selection: only one request high selects that requester; both high selects the requester not equal to last_owner (round-robin).
REQ-023 In IDLE, mem_req SHALL equal if_req|d_req, combinationally driven by the selected requester's fields.
REQ-024 IDLE transitions: mem_gnt high goes to WAIT_RESP; mem_gnt low goes to ISSUE with owner locked to the selection.
REQ-025 In ISSUE, mem_req SHALL be driven only from the locked owner; a newly arriving request from the other requester SHALL NOT change the owner.
REQ-026 ISSUE transitions: mem_gnt high goes to WAIT_RESP; owner's req dropped goes to IDLE with mem_req low that cycle (abandon, no grant).
REQ-027 Grant: x_gnt = mem_req & mem_gnt for the current owner/selection only; last_owner SHALL update to that requester on the grant edge.
REQ-028 mem_* fields for an IF request: mem_we=0, mem_be=4'hF, mem_addr=if_addr, mem_wdata=0.
REQ-029 mem_* fields for a D request: mem_we=(d_op==MEM_STORE), fields taken from the d_ inputs.
REQ-030 In WAIT_RESP, mem_req SHALL be 0 and all gnt outputs SHALL be 0.
REQ-031 In WAIT_RESP, mem_rvalid high SHALL assert owner x_rvalid=1, x_rdata=mem_rdata, x_err=0 combinationally, then go to IDLE.
REQ-032 The next request SHALL NOT be issued before the cycle after a response, giving one bubble minimum.
REQ-033 Watchdog: a 16-bit counter SHALL clear on entry to WAIT_RESP; in each WAIT_RESP cycle without mem_rvalid it increments, or at count TIMEOUT_CYCLES-1 instead produces owner x_rvalid=1, x_err=1, x_rdata=0 and goes to IDLE.
REQ-034 mem_rvalid in the watchdog expiry cycle SHALL win: normal response, err=0.
REQ-035 mem_rvalid in IDLE or ISSUE SHALL be ignored (no x_rvalid) and SHALL set err_spurious, which remains set until reset.
REQ-036 Non-owner rvalid, rdata and err outputs SHALL be 0 at all times.

Reset
REQ-037 While reset_n is low at a clock edge, the block SHALL set state=IDLE, owner=IF, last_owner=IF, counter=0 and err_spurious=0.
REQ-038 During reset, all outputs SHALL be 0 regardless of inputs; mem_req SHALL be 0 in the reset cycle.
REQ-039 Reset in ISSUE or WAIT_RESP SHALL abandon the transaction; a late mem_rvalid afterwards SHALL set err_spurious.

Verification
REQ-040 reset_n low 2 cycles with if_req=d_req=1 -> all outputs 0; first cycle after release mem_req=1, mem_addr=d_addr, d_gnt=1 (mem_gnt=1).
REQ-041 Both requesting continuously, mem_gnt=1, mem_rvalid one cycle after each grant -> grants D,IF,D,IF; responses are routed to the matching requester with data intact.
REQ-042 d_req store (addr 0x100, wdata 0xDEADBEEF, be 4'b0011), mem_gnt low 3 cycles, if_req rises in cycle 1 -> mem_addr=0x100, mem_we=1 held; d_gnt on cycle 3; if_gnt only after the D response.
REQ-043 TIMEOUT_CYCLES=4, IF granted at cycle 0, no mem_rvalid -> cycle 4: if_rvalid=1, if_err=1, if_rdata=0; cycle 5 in IDLE.
REQ-044 TIMEOUT_CYCLES=4, mem_rvalid with rdata 0x12345678 at cycle 4 -> err=0, rdata=0x12345678.
REQ-045 mem_rvalid pulsed in IDLE -> no x_rvalid; err_spurious=1 until next reset.

Source files
------------

// File: rtl/rv32i.sv
// Shared RV32I core types used by the memory arbiter ports.
package rv32i;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto a single memory port
// with one outstanding transaction, round-robin tie-break and a response watchdog.
module mem_arbiter
  import rv32i::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  // instruction fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  // data requester
  input  logic        d_req,
  input  mem_op_e     d_op,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // shared memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  // status
  output logic        err_spurious
);

  localparam int unsigned       CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               WDOG_EN  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  owner_e           last_owner_q, last_owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_spurious_q, err_spurious_d;

  // requester driving the port this cycle, and whether it is presenting a request
  owner_e           sel;
  logic             issue;
  // response to be routed to the owner this cycle
  logic             resp_valid;
  logic             resp_err;
  logic [31:0]      resp_data;

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      owner_q        <= OWN_IF;
      last_owner_q   <= OWN_IF;
      cnt_q          <= '0;
      err_spurious_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_owner_q   <= last_owner_d;
      cnt_q          <= cnt_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  // Arbitration, port muxing, response routing and watchdog; everything is forced low in reset
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    cnt_d          = cnt_q;
    err_spurious_d = err_spurious_q;
    sel            = owner_q;
    issue          = 1'b0;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    resp_data      = '0;

    if_gnt       = 1'b0;
    if_rvalid    = 1'b0;
    if_rdata     = '0;
    if_err       = 1'b0;
    d_gnt        = 1'b0;
    d_rvalid     = 1'b0;
    d_rdata      = '0;
    d_err        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = '0;
    err_spurious = 1'b0;

    if (reset_n) begin
      err_spurious = err_spurious_q;

      unique case (state_q)
        IDLE: begin
          if (if_req && d_req) begin
            sel = (last_owner_q == OWN_IF) ? OWN_D : OWN_IF;
          end else if (d_req) begin
            sel = OWN_D;
          end else begin
            sel = OWN_IF;
          end
          issue = if_req | d_req;
          if (mem_rvalid) err_spurious_d = 1'b1;
          if (issue) begin
            owner_d = sel;
            state_d = mem_gnt ? WAIT_RESP : ISSUE;
          end
        end

        ISSUE: begin
          sel   = owner_q;
          issue = (owner_q == OWN_IF) ? if_req : d_req;
          if (mem_rvalid) err_spurious_d = 1'b1;
          if (!issue) begin
            state_d = IDLE;
          end else if (mem_gnt) begin
            state_d = WAIT_RESP;
          end
        end

        WAIT_RESP: begin
          if (mem_rvalid) begin
            resp_valid = 1'b1;
            resp_data  = mem_rdata;
            state_d    = IDLE;
          end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: state_d = IDLE;
      endcase

      // drive the shared port from the selected requester
      if (issue) begin
        mem_req = 1'b1;
        if (sel == OWN_IF) begin
          mem_we    = 1'b0;
          mem_addr  = if_addr;
          mem_wdata = '0;
          mem_be    = 4'hF;
          if_gnt    = mem_gnt;
        end else begin
          mem_we    = (d_op == MEM_STORE);
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          mem_be    = d_be;
          d_gnt     = mem_gnt;
        end
        if (mem_gnt) begin
          last_owner_d = sel;
          cnt_d        = '0;
        end
      end

      // route the response to the owner only
      if (resp_valid) begin
        if (owner_q == OWN_IF) begin
          if_rvalid = 1'b1;
          if_rdata  = resp_data;
          if_err    = resp_err;
        end else begin
          d_rvalid = 1'b1;
          d_rdata  = resp_data;
          d_err    = resp_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a short watchdog (TIMEOUT_CYCLES=4).
module tb_mem_arbiter;
  import rv32i::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req;
  mem_op_e     d_op;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err_spurious;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge, where inputs are changed
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; if_req = 1'b1; d_req = 1'b1;
    if_addr = 32'h0000_0040; d_addr = 32'h0000_0200; d_op = MEM_LOAD;
    d_wdata = 32'h5555_AAAA; d_be = 4'hC;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    // reset with both requesting: everything low
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_err_spurious", 32'(err_spurious), 32'd0);
    tick();
    reset_n = 1'b1;

    // first cycle out of reset: D wins the tie (last_owner resets to IF)
    @(negedge clk);
    chk("rr0_mem_req", 32'(mem_req), 32'd1);
    chk("rr0_mem_addr", mem_addr, 32'h0000_0200);
    chk("rr0_mem_be", 32'(mem_be), 32'hC);
    chk("rr0_d_gnt", 32'(d_gnt), 32'd1);
    chk("rr0_if_gnt", 32'(if_gnt), 32'd0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hA0A0_0001;
    @(negedge clk);
    chk("rr0_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("rr0_d_rdata", d_rdata, 32'hA0A0_0001);
    chk("rr0_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rr0_wait_mem_req", 32'(mem_req), 32'd0);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rr1_if_gnt", 32'(if_gnt), 32'd1);
    chk("rr1_d_gnt", 32'(d_gnt), 32'd0);
    chk("rr1_mem_addr", mem_addr, 32'h0000_0040);
    chk("rr1_mem_be", 32'(mem_be), 32'hF);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hB0B0_0002;
    @(negedge clk);
    chk("rr1_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("rr1_if_rdata", if_rdata, 32'hB0B0_0002);
    chk("rr1_d_rdata", d_rdata, 32'h0);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rr2_d_gnt", 32'(d_gnt), 32'd1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hC3C3_0003;
    @(negedge clk);
    chk("rr2_d_rdata", d_rdata, 32'hC3C3_0003);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rr3_if_gnt", 32'(if_gnt), 32'd1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hD4D4_0004;
    @(negedge clk);
    chk("rr3_if_rdata", if_rdata, 32'hD4D4_0004);
    tick();
    mem_rvalid = 1'b0; if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("idle_mem_req", 32'(mem_req), 32'd0);

    // store stalled 3 cycles; IF arrives meanwhile and must wait
    tick();
    d_req = 1'b1; d_op = MEM_STORE; d_addr = 32'h0000_0100;
    d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011; mem_gnt = 1'b0;
    @(negedge clk);
    chk("st0_mem_addr", mem_addr, 32'h0000_0100);
    chk("st0_mem_we", 32'(mem_we), 32'd1);
    chk("st0_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st0_mem_be", 32'(mem_be), 32'h3);
    chk("st0_d_gnt", 32'(d_gnt), 32'd0);
    tick();
    if_req = 1'b1; if_addr = 32'h0000_0044;
    @(negedge clk);
    chk("st1_mem_addr", mem_addr, 32'h0000_0100);
    chk("st1_mem_we", 32'(mem_we), 32'd1);
    chk("st1_if_gnt", 32'(if_gnt), 32'd0);
    tick();
    @(negedge clk);
    chk("st2_mem_addr", mem_addr, 32'h0000_0100);
    chk("st2_d_gnt", 32'(d_gnt), 32'd0);
    tick();
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("st3_d_gnt", 32'(d_gnt), 32'd1);
    chk("st3_if_gnt", 32'(if_gnt), 32'd0);
    chk("st3_mem_we", 32'(mem_we), 32'd1);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    chk("st4_mem_req", 32'(mem_req), 32'd0);
    chk("st4_if_gnt", 32'(if_gnt), 32'd0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0;
    @(negedge clk);
    chk("st5_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("st5_d_err", 32'(d_err), 32'd0);
    chk("st5_if_gnt", 32'(if_gnt), 32'd0);

    // IF granted, then no response: watchdog fires on the 4th wait cycle
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("to_if_gnt", 32'(if_gnt), 32'd1);
    chk("to_mem_addr", mem_addr, 32'h0000_0044);
    tick();
    if_req = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    tick();
    @(negedge clk);
    chk("to_c2_if_rvalid", 32'(if_rvalid), 32'd0);
    tick();
    @(negedge clk);
    chk("to_c3_if_rvalid", 32'(if_rvalid), 32'd0);
    tick();
    @(negedge clk);
    chk("to_c4_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("to_c4_if_err", 32'(if_err), 32'd1);
    chk("to_c4_if_rdata", if_rdata, 32'h0);
    chk("to_c4_d_rvalid", 32'(d_rvalid), 32'd0);
    tick();
    if_req = 1'b1;
    @(negedge clk);
    chk("to_c5_idle_if_gnt", 32'(if_gnt), 32'd1);
    chk("to_c5_if_rvalid", 32'(if_rvalid), 32'd0);

    // response arriving in the expiry cycle wins
    tick();
    if_req = 1'b0;
    tick();
    tick();
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("race_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("race_if_err", 32'(if_err), 32'd0);
    chk("race_if_rdata", if_rdata, 32'h1234_5678);

    // response in IDLE is spurious and sticky
    tick();
    mem_rvalid = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("sp_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("sp_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("sp_before", 32'(err_spurious), 32'd0);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("sp_set", 32'(err_spurious), 32'd1);
    tick();
    tick();
    @(negedge clk);
    chk("sp_sticky", 32'(err_spurious), 32'd1);
    tick();
    reset_n = 1'b0;
    @(negedge clk);
    chk("sp_rst_low", 32'(err_spurious), 32'd0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("sp_cleared", 32'(err_spurious), 32'd0);

    // reset while waiting abandons; the late response is spurious
    tick();
    if_req = 1'b1; if_addr = 32'h0000_0080; mem_gnt = 1'b1;
    @(negedge clk);
    chk("ab_if_gnt", 32'(if_gnt), 32'd1);
    tick();
    if_req = 1'b0; reset_n = 1'b0;
    tick();
    reset_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("ab_late_if_rvalid", 32'(if_rvalid), 32'd0);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("ab_late_spurious", 32'(err_spurious), 32'd1);

    // owner drops its request in ISSUE: abandoned, other requester not granted that cycle
    tick();
    d_req = 1'b1; d_op = MEM_LOAD; d_addr = 32'h0000_0300; mem_gnt = 1'b0;
    @(negedge clk);
    chk("is_d_gnt", 32'(d_gnt), 32'd0);
    tick();
    d_req = 1'b0; if_req = 1'b1; mem_gnt = 1'b1;
    @(negedge clk);
    chk("is_drop_mem_req", 32'(mem_req), 32'd0);
    chk("is_drop_if_gnt", 32'(if_gnt), 32'd0);
    tick();
    @(negedge clk);
    chk("is_next_if_gnt", 32'(if_gnt), 32'd1);
    chk("is_next_mem_addr", mem_addr, 32'h0000_0080);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
